// File: rtl/data_memory_bhw_if.sv
// Requester-side bus of the MEM-stage data memory: load/store command, data and handshake.
interface data_memory_bhw_if;
  logic [3:0]  read;
  logic [2:0]  write;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;
  logic        misaligned;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait, misaligned
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait, misaligned
  );
endinterface

// File: rtl/data_memory_bhw.sv
// RV32IM data memory: byte/half/word loads and stores, configurable wait latency,
// post-reset clear sweep and misaligned-access suppression.
module data_memory_bhw #(
  parameter int ADDR_WIDTH     = 10,
  parameter int LATENCY        = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic               clock,
  input logic               reset,
  data_memory_bhw_if.slave  bus
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_DONE} state_t;

  function automatic logic op_valid(input logic [3:0] rd, input logic [2:0] wr);
    logic v;
    v = 1'b0;
    if (rd[3] && !wr[2]) begin
      case (rd[2:0])
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: v = 1'b1;
        default:                                v = 1'b0;
      endcase
    end else if (wr[2] && !rd[3]) begin
      v = (wr[1:0] != 2'b11);
    end else begin
      v = 1'b0;
    end
    return v;
  endfunction

  function automatic logic op_misaligned(input logic [3:0] rd, input logic [2:0] wr,
                                         input logic [1:0] lane);
    logic m;
    m = 1'b0;
    if (rd[3]) begin
      case (rd[2:0])
        3'b001, 3'b101: m = lane[0];
        3'b010:         m = (lane != 2'b00);
        default:        m = 1'b0;
      endcase
    end else begin
      case (wr[1:0])
        2'b01:   m = lane[0];
        2'b10:   m = (lane != 2'b00);
        default: m = 1'b0;
      endcase
    end
    return m;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] data,
                                              input logic [1:0] f2, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (f2)
      2'b00:   r[{lane, 3'b000} +: 8] = data[7:0];
      2'b01:   if (lane[1]) r[31:16] = data[15:0]; else r[15:0] = data[15:0];
      2'b10:   r = data;
      default: r = old;
    endcase
    return r;
  endfunction

  logic [31:0]           mem_r [DEPTH];
  state_t                state_r, next_state_s;
  logic [IDX_W-1:0]      clr_ptr_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [3:0]            lat_read_r;
  logic [2:0]            lat_write_r;
  logic [ADDR_WIDTH-1:0] lat_addr_r;
  logic [31:0]           lat_wdata_r;
  logic [31:0]           readdata_r;
  logic                  misaligned_r;

  logic [3:0]            op_read_s;
  logic [2:0]            op_write_s;
  logic [ADDR_WIDTH-1:0] op_addr_s;
  logic [31:0]           op_wdata_s;
  logic [31:0]           rd_word_s;
  logic                  req_ok_s, acc_go_s, acc_mis_s, busywait_s;
  logic                  mem_we_s;
  logic [IDX_W-1:0]      mem_waddr_s;
  logic [31:0]           mem_wdata_s;
  logic                  unused_s;

  assign unused_s         = ^bus.address[31:ADDR_WIDTH];
  assign req_ok_s         = op_valid(bus.read, bus.write);
  assign rd_word_s        = mem_r[op_addr_s[ADDR_WIDTH-1:2]];
  assign acc_mis_s        = op_misaligned(op_read_s, op_write_s, op_addr_s[1:0]);
  assign bus.readdata     = readdata_r;
  assign bus.misaligned   = misaligned_r;
  assign bus.busywait     = busywait_s;

  // Single-cycle mode acts on the live bus; otherwise the latched request is used in WAIT.
  always_comb begin
    if (LATENCY == 0) begin
      op_read_s  = bus.read;
      op_write_s = bus.write;
      op_addr_s  = bus.address[ADDR_WIDTH-1:0];
      op_wdata_s = bus.writedata;
      acc_go_s   = (state_r == ST_IDLE) && req_ok_s;
    end else begin
      op_read_s  = lat_read_r;
      op_write_s = lat_write_r;
      op_addr_s  = lat_addr_r;
      op_wdata_s = lat_wdata_r;
      acc_go_s   = (state_r == ST_WAIT) && (cnt_r == {CNT_W{1'b0}});
    end
  end

  // Next-state and busywait decode.
  always_comb begin
    next_state_s = state_r;
    busywait_s   = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        busywait_s = 1'b1;
        if (clr_ptr_r == IDX_W'(DEPTH - 1)) next_state_s = ST_IDLE;
        else                                next_state_s = ST_CLEAR;
      end
      ST_IDLE: begin
        if (LATENCY == 0) begin
          busywait_s = 1'b0;
        end else begin
          busywait_s = req_ok_s;
          if (req_ok_s) next_state_s = ST_WAIT;
          else          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        busywait_s = 1'b1;
        if (cnt_r == {CNT_W{1'b0}}) next_state_s = ST_DONE;
        else                        next_state_s = ST_WAIT;
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Memory write port: clear sweep or an aligned store; gated off while reset is asserted.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = op_addr_s[ADDR_WIDTH-1:2];
    mem_wdata_s = 32'd0;
    if (!reset) begin
      mem_we_s = 1'b0;
    end else if (state_r == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_ptr_r;
    end else if (acc_go_s && op_write_s[2] && !acc_mis_s) begin
      mem_we_s    = 1'b1;
      mem_wdata_s = store_merge(rd_word_s, op_wdata_s, op_write_s[1:0], op_addr_s[1:0]);
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Storage array.
  always_ff @(posedge clock) begin
    if (mem_we_s) mem_r[mem_waddr_s] <= mem_wdata_s;
  end

  // FSM state, clear pointer, request latch, wait counter and registered results.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_ptr_r    <= {IDX_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      lat_read_r   <= 4'd0;
      lat_write_r  <= 3'd0;
      lat_addr_r   <= {ADDR_WIDTH{1'b0}};
      lat_wdata_r  <= 32'd0;
      readdata_r   <= 32'd0;
      misaligned_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (state_r == ST_CLEAR) clr_ptr_r <= clr_ptr_r + IDX_W'(1);
      if ((LATENCY != 0) && (state_r == ST_IDLE) && req_ok_s) begin
        lat_read_r  <= bus.read;
        lat_write_r <= bus.write;
        lat_addr_r  <= bus.address[ADDR_WIDTH-1:0];
        lat_wdata_r <= bus.writedata;
        cnt_r       <= CNT_W'(LATENCY - 1);
      end else if ((state_r == ST_WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
      if (acc_go_s) begin
        if (acc_mis_s) begin
          misaligned_r <= 1'b1;
          readdata_r   <= 32'd0;
        end else begin
          misaligned_r <= 1'b0;
          if (op_read_s[3]) readdata_r <= load_extract(rd_word_s, op_read_s[2:0], op_addr_s[1:0]);
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_bhw.sv
// Randomised scoreboard bench for data_memory_bhw against a byte-array reference model.
module tb_data_memory_bhw;

  localparam int LAT = 2;

  localparam logic [3:0] LB  = 4'b1000, LH  = 4'b1001, LW = 4'b1010;
  localparam logic [3:0] LBU = 4'b1100, LHU = 4'b1101, NL = 4'b0000;
  localparam logic [2:0] SB  = 3'b100,  SH  = 3'b101,  SW = 3'b110, NS = 3'b000;

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
  } sb_t;

  logic clock;
  logic reset;
  data_memory_bhw_if bus();

  data_memory_bhw #(.ADDR_WIDTH(10), .LATENCY(LAT), .CLEAR_ON_RESET(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  sb_t         sb_q[$];
  logic [7:0]  mem_m [1024];
  logic [31:0] m_rd;
  logic        m_mis;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [9:0] ba);
    logic [9:0]  wb, hb;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    wb = {ba[9:2], 2'b00};
    hb = {ba[9:1], 1'b0};
    b  = mem_m[ba];
    h  = {mem_m[hb + 10'd1], mem_m[hb]};
    w  = {mem_m[wb + 10'd3], mem_m[wb + 10'd2], mem_m[wb + 10'd1], mem_m[wb]};
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_store(input logic [1:0] f2, input logic [9:0] ba, input logic [31:0] wd);
    for (int k = 0; k < (1 << f2); k++) mem_m[ba + 10'(k)] = wd[8*k +: 8];
  endtask

  task automatic drive(input logic [3:0] rd, input logic [2:0] wr,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = a;
    bus.writedata = wd;
  endtask

  // Full access: model update, scoreboard push, busywait length and no re-execution check.
  task automatic access(input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] a, input logic [31:0] wd);
    logic       ld, st, valid, mis;
    logic [1:0] sz;
    logic [9:0] ba;
    int         n;
    ld = rd[3];
    st = wr[2];
    ba = a[9:0];
    valid = 1'b0;
    if (ld && !st)      valid = (rd[2:0] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (st && !ld) valid = (wr[1:0] != 2'b11);
    @(posedge clock); #1;
    drive(rd, wr, a, wd);
    if (!valid) begin
      @(negedge clock);
      chk("noop_busywait", {31'd0, bus.busywait}, 32'd0);
      @(posedge clock); #1;
      drive(NL, NS, 32'd0, 32'd0);
      @(negedge clock);
      chk("noop_readdata", bus.readdata, m_rd);
      chk("noop_misaligned", {31'd0, bus.misaligned}, {31'd0, m_mis});
      return;
    end
    sz  = ld ? rd[1:0] : wr[1:0];
    mis = ((sz == 2'd1) && ba[0]) || ((sz == 2'd2) && (ba[1:0] != 2'b00));
    if (mis) begin
      m_rd  = 32'd0;
      m_mis = 1'b1;
    end else begin
      m_mis = 1'b0;
      if (ld) m_rd = m_load(rd[2:0], ba);
      else    m_store(sz, ba, wd);
    end
    sb_q.push_back('{rd: m_rd, mis: m_mis});
    n = 0;
    forever begin
      @(negedge clock);
      if (!bus.busywait) break;
      n++;
      if (n > 20) begin
        chk("busywait_timeout", 32'(n), 32'(LAT + 1));
        break;
      end
    end
    chk("busy_cycles", 32'(n), 32'(LAT + 1));
    @(posedge clock); #1;
    drive(NL, NS, 32'd0, 32'd0);
    @(negedge clock);
    chk("no_reexec", {31'd0, bus.busywait}, 32'd0);
  endtask

  task automatic do_reset();
    int n;
    sb_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    drive(NL, NS, 32'd0, 32'd0);
    #2;
    chk("reset_readdata", bus.readdata, 32'd0);
    chk("reset_misaligned", {31'd0, bus.misaligned}, 32'd0);
    for (int i = 0; i < 1024; i++) mem_m[i] = 8'd0;
    m_rd  = 32'd0;
    m_mis = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      if (!bus.busywait) break;
      n++;
      if (n > 400) break;
    end
    chk("clear_cycles", 32'(n), 32'd256);
  endtask

  // Monitor: a result is presented when busywait falls after an access.
  initial begin
    sb_t e;
    logic prev_bw;
    prev_bw = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_bw = 1'b0;
      end else begin
        if (prev_bw && !bus.busywait && (sb_q.size() > 0)) begin
          e = sb_q.pop_front();
          chk("readdata", bus.readdata, e.rd);
          chk("misaligned", {31'd0, bus.misaligned}, {31'd0, e.mis});
        end
        prev_bw = bus.busywait;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] a;
    int          sel;
    reset = 1'b1;
    drive(NL, NS, 32'd0, 32'd0);
    do_reset();
    access(LW, NS, 32'h0000_0000, 32'd0);

    access(NL, SW, 32'h0000_0010, 32'h8081_F2A3);
    access(LB,  NS, 32'h0000_0010, 32'd0);
    access(LBU, NS, 32'h0000_0013, 32'd0);
    access(LH,  NS, 32'h0000_0012, 32'd0);
    access(LHU, NS, 32'h0000_0010, 32'd0);

    access(NL, SW, 32'h0000_0020, 32'h1122_3344);
    access(NL, SB, 32'h0000_0021, 32'h0000_0055);
    access(LW, NS, 32'h0000_0020, 32'd0);
    access(NL, SH, 32'h0000_0022, 32'h0000_BEEF);
    access(LW, NS, 32'h0000_0020, 32'd0);

    access(NL, SW, 32'h0000_0004, 32'hCAFE_0123);
    access(LW, NS, 32'h0000_0006, 32'd0);
    access(NL, SH, 32'h0000_0005, 32'h0000_9999);
    access(LW, NS, 32'h0000_0004, 32'd0);

    access(NL, SW, 32'h0000_0400, 32'hA5A5_5A5A);
    access(LW, NS, 32'h0000_0000, 32'd0);

    access(LW | 4'b0001, NS, 32'h0000_0010, 32'd0);
    access(LW, SW, 32'h0000_0010, 32'h1234_5678);
    access(NL, 3'b111, 32'h0000_0010, 32'h1234_5678);

    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 19);
      rd  = NL;
      wr  = NS;
      if (sel < 9)        rd = {1'b1, 3'($urandom_range(0, 7))};
      else if (sel < 18)  wr = {1'b1, 2'($urandom_range(0, 3))};
      else if (sel == 18) begin rd = LW; wr = SW; end
      a = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'd0, 10'($urandom_range(0, 127))};
      access(rd, wr, a, $urandom);
    end

    access(NL, SW, 32'h0000_0040, 32'h1234_5678);
    access(LW, NS, 32'h0000_0040, 32'd0);
    @(posedge clock); #1;
    drive(NL, SW, 32'h0000_0030, 32'hDEAD_BEEF);
    @(negedge clock);
    do_reset();
    access(LW, NS, 32'h0000_0030, 32'd0);

    repeat (4) @(posedge clock);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
